// File: rtl/btc_tile_sched_pkg.sv
// btc_sched_pkg: shared types for the bTensorCore tile scheduler.
//   - sched_state_e : scheduler FSM states
//   - CORE_LAT_DEF  : default core latency (activation_update -> result_out valid)
//   - strobe_t      : bundle of the per-cycle strobes sent to the core
package btc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDW  = 3'd1,
    ST_LDA  = 3'd2,
    ST_WAIT = 3'd3,
    ST_OUT  = 3'd4
  } sched_state_e;

  localparam int CORE_LAT_DEF = 3;

  typedef struct packed {
    logic weight_update;
    logic activation_update;
    logic psum_update;
    logic psum_zero;
  } strobe_t;

endpackage

// File: rtl/btc_tile_sched_if.sv
// btc_tile_sched_if: handshake and strobe bundle between the tile scheduler,
// the weight/activation tile buffers, the core and the result consumer.
//   master : scheduler side (drives readies, strobes, res_valid/res_last)
//   slave  : environment side (drives w_valid, a_valid, res_ready)
interface btc_tile_sched_if;

  logic w_valid;
  logic w_ready;
  logic a_valid;
  logic a_ready;
  logic weight_update;
  logic activation_update;
  logic psum_update;
  logic psum_zero;
  logic res_valid;
  logic res_ready;
  logic res_last;

  modport master (
    input  w_valid, a_valid, res_ready,
    output w_ready, a_ready, weight_update, activation_update,
           psum_update, psum_zero, res_valid, res_last
  );

  modport slave (
    output w_valid, a_valid, res_ready,
    input  w_ready, a_ready, weight_update, activation_update,
           psum_update, psum_zero, res_valid, res_last
  );

endinterface

// File: rtl/btc_lat_timer.sv
// btc_lat_timer: loadable down-counter with a terminal-count (zero) flag.
// Used by the scheduler to time the core latency in WAIT.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero
//   zero      : count is zero
module btc_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/btc_tile_sched.sv
// btc_tile_sched: N x K tile-loop scheduler for the four-octet bTensorCore.
// Pulls weight and activation tiles over valid/ready, strobes the core and
// hands each finished N-tile result downstream. Control only, no data path.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start             : launch a job (sampled only in IDLE)
//   cfg_k_tiles       : K tiles per output tile (0 treated as 1)
//   cfg_n_tiles       : output tiles per job (0 treated as 1)
//   bus (master)      : w/a/res handshakes and core strobes, see btc_tile_sched_if
//   k_idx, n_idx      : current K / N tile index
//   busy              : state is not IDLE
//   done              : one-cycle pulse at job completion
//   perf_busy_cyc     : (SCHED_PERF_CNT_EN) cycles with busy=1, saturating
//   perf_stall_cyc    : (SCHED_PERF_CNT_EN) cycles waiting on w_valid/a_valid/res_ready
//
// Build option: define SCHED_PERF_CNT_EN to add the two perf counter outputs.
//
// State table
//   state | meaning
//   IDLE  | waiting for start
//   LDW   | w_ready=1, waiting for a weight tile
//   LDA   | a_ready=1, waiting for an activation tile
//   WAIT  | core latency countdown after activation_update
//   OUT   | res_valid=1, waiting for res_ready
module btc_tile_sched
  import btc_sched_pkg::*;
#(
  parameter int K_W      = 8,
  parameter int N_W      = 8,
  parameter int CORE_LAT = CORE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    cfg_k_tiles,
  input  logic [N_W-1:0]    cfg_n_tiles,
  btc_tile_sched_if.master  bus,
  output logic [K_W-1:0]    k_idx,
  output logic [N_W-1:0]    n_idx,
  output logic              busy,
  output logic              done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
`endif
);

  // Timer holds CORE_LAT-1; WAIT lasts exactly CORE_LAT cycles.
  localparam int TMR_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CORE_LAT - 1);

  sched_state_e   state_q, state_d;
  logic [K_W-1:0] k_last_q, k_last_d;
  logic [N_W-1:0] n_last_q, n_last_d;
  logic [K_W-1:0] k_idx_q, k_idx_d;
  logic [N_W-1:0] n_idx_q, n_idx_d;
  logic           w_ready_q, w_ready_d;
  logic           a_ready_q, a_ready_d;
  logic           res_valid_q, res_valid_d;
  logic           res_last_q, res_last_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  strobe_t        strb_q, strb_d;

  logic tmr_load, tmr_dec, tmr_zero;
  logic w_fire, a_fire, res_fire, start_acc;

  assign w_fire    = bus.w_valid & w_ready_q;
  assign a_fire    = bus.a_valid & a_ready_q;
  assign res_fire  = res_valid_q & bus.res_ready;
  assign start_acc = (state_q == ST_IDLE) & start;

  btc_lat_timer #(.W(TMR_W)) u_lat_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TMR_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    k_last_d    = k_last_q;
    n_last_d    = n_last_q;
    k_idx_d     = k_idx_q;
    n_idx_d     = n_idx_q;
    w_ready_d   = w_ready_q;
    a_ready_d   = a_ready_q;
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    strb_d      = '0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Store last index rather than count so 0 and 1 both mean one tile.
          k_last_d  = (cfg_k_tiles == '0) ? '0 : cfg_k_tiles - K_W'(1);
          n_last_d  = (cfg_n_tiles == '0) ? '0 : cfg_n_tiles - N_W'(1);
          k_idx_d   = '0;
          n_idx_d   = '0;
          w_ready_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_LDW;
        end
      end
      ST_LDW: begin
        if (w_fire) begin
          w_ready_d            = 1'b0;
          a_ready_d            = 1'b1;
          strb_d.weight_update = 1'b1;
          state_d              = ST_LDA;
        end
      end
      ST_LDA: begin
        if (a_fire) begin
          a_ready_d                = 1'b0;
          tmr_load                 = 1'b1;
          strb_d.activation_update = 1'b1;
          strb_d.psum_update       = 1'b1;
          strb_d.psum_zero         = (k_idx_q == '0);
          state_d                  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          if (k_idx_q != k_last_q) begin
            k_idx_d   = k_idx_q + K_W'(1);
            w_ready_d = 1'b1;
            state_d   = ST_LDW;
          end else begin
            res_valid_d = 1'b1;
            res_last_d  = (n_idx_q == n_last_q);
            state_d     = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (res_fire) begin
          res_valid_d = 1'b0;
          res_last_d  = 1'b0;
          if (n_idx_q != n_last_q) begin
            k_idx_d   = '0;
            n_idx_d   = n_idx_q + N_W'(1);
            w_ready_d = 1'b1;
            state_d   = ST_LDW;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        w_ready_d   = 1'b0;
        a_ready_d   = 1'b0;
        res_valid_d = 1'b0;
        res_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_last_q    <= '0;
      n_last_q    <= '0;
      k_idx_q     <= '0;
      n_idx_q     <= '0;
      w_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      strb_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_last_q    <= k_last_d;
      n_last_q    <= n_last_d;
      k_idx_q     <= k_idx_d;
      n_idx_q     <= n_idx_d;
      w_ready_q   <= w_ready_d;
      a_ready_q   <= a_ready_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      strb_q      <= strb_d;
    end
  end

  assign bus.w_ready           = w_ready_q;
  assign bus.a_ready           = a_ready_q;
  assign bus.weight_update     = strb_q.weight_update;
  assign bus.activation_update = strb_q.activation_update;
  assign bus.psum_update       = strb_q.psum_update;
  assign bus.psum_zero         = strb_q.psum_zero;
  assign bus.res_valid         = res_valid_q;
  assign bus.res_last          = res_last_q;
  assign k_idx                 = k_idx_q;
  assign n_idx                 = n_idx_q;
  assign busy                  = busy_q;
  assign done                  = done_q;

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] busy_cyc_q, busy_cyc_d;
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic        stall;

  assign stall = ((state_q == ST_LDW) & ~bus.w_valid) |
                 ((state_q == ST_LDA) & ~bus.a_valid) |
                 ((state_q == ST_OUT) & ~bus.res_ready);

  always_comb begin
    busy_cyc_d  = busy_cyc_q;
    stall_cyc_d = stall_cyc_q;
    if (start_acc) begin
      busy_cyc_d  = '0;
      stall_cyc_d = '0;
    end else begin
      if (busy_q && (busy_cyc_q != '1)) begin
        busy_cyc_d = busy_cyc_q + 32'd1;
      end
      if (stall && (stall_cyc_q != '1)) begin
        stall_cyc_d = stall_cyc_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      busy_cyc_q  <= busy_cyc_d;
      stall_cyc_q <= stall_cyc_d;
    end
  end

  assign perf_busy_cyc  = busy_cyc_q;
  assign perf_stall_cyc = stall_cyc_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_btc_tile_sched.sv
// Testbench for btc_tile_sched (CORE_LAT=3, K_W=N_W=8).
// Directed jobs with hand-computed expected strobe timing and counts.
module tb_btc_tile_sched;
  import btc_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_k = 8'd0;
  logic [7:0] cfg_n = 8'd0;
  logic [7:0] k_idx, n_idx;
  logic       busy, done;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  btc_tile_sched_if bi();

  btc_tile_sched #(.K_W(8), .N_W(8), .CORE_LAT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cfg_k_tiles (cfg_k),
    .cfg_n_tiles (cfg_n),
    .bus         (bi.master),
    .k_idx       (k_idx),
    .n_idx       (n_idx),
    .busy        (busy),
    .done        (done)
`ifdef SCHED_PERF_CNT_EN
    ,
    .perf_busy_cyc  (perf_busy),
    .perf_stall_cyc (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {busy, done, res_valid, res_last, psum_zero, psum_update, activation_update, weight_update, w_ready, a_ready}
  function automatic logic [9:0] vec();
    return {busy, done, bi.res_valid, bi.res_last, bi.psum_zero, bi.psum_update,
            bi.activation_update, bi.weight_update, bi.w_ready, bi.a_ready};
  endfunction

  // Event counters: strobes sampled on negedge, handshake fires on posedge.
  int wu_n = 0, au_n = 0, pu_n = 0, pz_n = 0, done_n = 0, busy_n = 0;
  int wf_n = 0, rf_n = 0;
  logic [31:0] kseq = '0;
  logic [31:0] nseq = '0;

  always @(negedge clk) begin
    if (bi.weight_update) wu_n++;
    if (bi.activation_update) au_n++;
    if (bi.psum_update) begin
      pu_n++;
      if (bi.psum_zero) pz_n++;
      kseq = {kseq[23:0], k_idx};
    end
    if (done) done_n++;
    if (busy) busy_n++;
  end

  always @(posedge clk) begin
    if (bi.w_valid && bi.w_ready) wf_n++;
    if (bi.res_valid && bi.res_ready) begin
      rf_n++;
      nseq = {nseq[23:0], n_idx};
    end
  end

  int s_wu, s_au, s_pu, s_pz, s_done, s_busy, s_wf, s_rf;

  task automatic snap();
    s_wu = wu_n; s_au = au_n; s_pu = pu_n; s_pz = pz_n;
    s_done = done_n; s_busy = busy_n; s_wf = wf_n; s_rf = rf_n;
  endtask

  // Returns at the negedge of the first cycle after start is accepted.
  task automatic launch(input logic [7:0] k, input logic [7:0] n);
    @(negedge clk);
    cfg_k = k;
    cfg_n = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_res(input string tag, input int budget);
    int i;
    i = 0;
    while (!bi.res_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!bi.res_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [9:0] tim_exp [8];
  int hold, ok_n;
  logic lastv;

  initial begin
    tim_exp = '{10'h202, 10'h205, 10'h238, 10'h200, 10'h200, 10'h2C0, 10'h100, 10'h000};
    bi.w_valid   = 1'b1;
    bi.a_valid   = 1'b1;
    bi.res_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_vec", 32'(vec()), 32'd0);
    chk("rst_idx", {16'd0, k_idx, n_idx}, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
`ifdef SCHED_PERF_CNT_EN
    chk("rst_perf", perf_busy | perf_stall, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_valids_ignored", 32'(vec()), 32'd0);

    // 1x1 cycle-by-cycle timing
    snap();
    launch(8'd1, 8'd1);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t1x1_c%0d", c + 1), 32'(vec()), 32'(tim_exp[c]));
      @(negedge clk);
    end
    chk("t1x1_wfire", 32'(wf_n - s_wf), 32'd1);

    // k=4, n=1
    snap();
    launch(8'd4, 8'd1);
    wait_done("k4", 100);
    chk("k4_wu", 32'(wu_n - s_wu), 32'd4);
    chk("k4_pu", 32'(pu_n - s_pu), 32'd4);
    chk("k4_au", 32'(au_n - s_au), 32'd4);
    chk("k4_pz", 32'(pz_n - s_pz), 32'd1);
    chk("k4_kseq", kseq, 32'h00010203);
    chk("k4_res", 32'(rf_n - s_rf), 32'd1);
    chk("k4_busy_cyc", 32'(busy_n - s_busy), 32'd21);
    chk("k4_done", 32'(done_n - s_done), 32'd1);

    // k=2, n=3, res_ready low for 5 cycles at each OUT
    bi.res_ready = 1'b0;
    snap();
    launch(8'd2, 8'd3);
    for (int i = 0; i < 3; i++) begin
      wait_res("k2n3", 100);
      hold = 0;
      lastv = 1'b0;
      for (int j = 0; j < 5; j++) begin
        if (bi.res_valid && (bi.res_last == (n_idx == 8'd2))) hold++;
        lastv = bi.res_last;
        @(negedge clk);
      end
      chk($sformatf("k2n3_hold%0d", i), 32'(hold), 32'd5);
      chk($sformatf("k2n3_last%0d", i), 32'(lastv), (i == 2) ? 32'd1 : 32'd0);
`ifdef SCHED_PERF_CNT_EN
      chk($sformatf("k2n3_stall%0d", i), perf_stall, 32'(5 * (i + 1)));
`endif
      bi.res_ready = 1'b1;
      @(negedge clk);
      bi.res_ready = 1'b0;
    end
    @(negedge clk);
    bi.res_ready = 1'b1;
    chk("k2n3_wfire", 32'(wf_n - s_wf), 32'd6);
    chk("k2n3_pz", 32'(pz_n - s_pz), 32'd3);
    chk("k2n3_nseq", nseq & 32'h00FFFFFF, 32'h00000102);
    chk("k2n3_busy_cyc", 32'(busy_n - s_busy), 32'd48);
    chk("k2n3_done", 32'(done_n - s_done), 32'd1);

    // w_valid low for 7 cycles in LDW
    bi.w_valid = 1'b0;
    snap();
    launch(8'd1, 8'd1);
    ok_n = 0;
    for (int j = 0; j < 7; j++) begin
      if (vec() == 10'h202) ok_n++;
      @(negedge clk);
    end
    chk("wstall_hold", 32'(ok_n), 32'd7);
    bi.w_valid = 1'b1;
    wait_done("wstall", 50);
    chk("wstall_wu", 32'(wu_n - s_wu), 32'd1);
    chk("wstall_busy_cyc", 32'(busy_n - s_busy), 32'd13);
`ifdef SCHED_PERF_CNT_EN
    chk("wstall_perf_stall", perf_stall, 32'd7);
    chk("wstall_perf_busy", perf_busy, 32'd13);
`endif

    // cfg 0x0 behaves as 1x1; start while busy ignored
    snap();
    launch(8'd0, 8'd0);
    @(negedge clk);
    cfg_k = 8'd5;
    cfg_n = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("cfg0", 50);
    chk("cfg0_wu", 32'(wu_n - s_wu), 32'd1);
    chk("cfg0_res", 32'(rf_n - s_rf), 32'd1);
    chk("cfg0_busy_cyc", 32'(busy_n - s_busy), 32'd6);
    repeat (3) @(negedge clk);
    chk("cfg0_idle", 32'(busy), 32'd0);
    chk("cfg0_done", 32'(done_n - s_done), 32'd1);

    // Reset mid-job during WAIT
    launch(8'd1, 8'd1);
    repeat (3) @(negedge clk);
    chk("mid_state_wait", 32'(dut.state_q), 32'(ST_WAIT));
    snap();
    rst = 1'b1;
    #1;
    chk("mid_rst_vec", 32'(vec()), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("mid_rst_vec2", 32'(vec()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_no_done", 32'(done_n - s_done), 32'd0);
    chk("mid_idle", 32'(busy), 32'd0);
    snap();
    launch(8'd1, 8'd1);
    wait_done("recover", 50);
    chk("recover_done", 32'(done_n - s_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
